// File: rtl/axi4_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_arbiter_if
// Brief    : Requester-side and memory-side bus of the memory arbiter.
// Revision : 1.0
// ============================================================================
interface axi4_mem_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            req_we;
   logic [NUM_REQ-1:0]            req_lock;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]         rdata;
   logic                          mem_en;
   logic                          mem_we;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0]         mem_wdata;
   logic [DATA_WIDTH-1:0]         mem_rdata;

   // Arbiter side
   modport slave (
      input  req, req_we, req_lock, req_addr, req_wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requesters plus the memory instance
   modport master (
      output req, req_we, req_lock, req_addr, req_wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/axi4_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_arbiter
// Brief    : Round-robin arbiter with burst lock and hold limit in front of a
//            single-port memory; registered memory port, routed read return.
// Revision : 1.0
// ============================================================================
module axi4_mem_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_HOLD   = 16
) (
   input  wire logic          ACLK,
   input  wire logic          ARESETn,
   axi4_mem_arbiter_if.slave  bus
);
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(MAX_HOLD);

   logic [IDX_W-1:0]      r_rr_ptr;
   logic [IDX_W-1:0]      r_owner;
   logic                  r_locked;
   logic [HOLD_W-1:0]     r_hold_cnt;
   logic [NUM_REQ-1:0]    r_rd_pend;
   logic [NUM_REQ-1:0]    r_rvalid;
   logic                  r_mem_en;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   logic [NUM_REQ-1:0]    w_owner_oh;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_owner_req;
   logic                  w_forced;
   logic                  w_owner_keeps;
   logic                  w_accept;
   logic [IDX_W-1:0]      w_k;
   logic                  w_k_we;
   logic                  w_k_lock;
   logic [ADDR_WIDTH-1:0] w_k_addr;
   logic [DATA_WIDTH-1:0] w_k_wdata;

   always_comb begin : p_owner_oh
      w_owner_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == r_owner) w_owner_oh[i] = 1'b1;
      end
   end

   assign w_owner_req   = |(bus.req & w_owner_oh);
   // A locked owner at its hold limit yields whenever anyone else is waiting
   assign w_forced      = r_locked && (r_hold_cnt == c_HOLD_MAX) && |(bus.req & ~w_owner_oh);
   assign w_owner_keeps = r_locked && w_owner_req && !w_forced;

   always_comb begin : p_grant
      int               start;
      logic [IDX_W-1:0] idx;
      logic             found;
      w_gnt = '0;
      found = 1'b0;
      idx   = '0;
      start = w_forced ? int'(r_owner) + 1 : int'(r_rr_ptr) + 1;
      if (w_owner_keeps) begin
         w_gnt = w_owner_oh;
      end else begin
         for (int j = 0; j < NUM_REQ; j++) begin
            idx = IDX_W'((start + j) % NUM_REQ);
            if (!found && bus.req[idx] && !(w_forced && (idx == r_owner))) begin
               w_gnt[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   always_comb begin : p_select
      w_k       = '0;
      w_k_we    = 1'b0;
      w_k_lock  = 1'b0;
      w_k_addr  = '0;
      w_k_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_k       = IDX_W'(i);
            w_k_we    = bus.req_we[i];
            w_k_lock  = bus.req_lock[i];
            w_k_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_k_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_accept = |(bus.req & w_gnt);

   always_ff @(posedge ACLK or negedge ARESETn) begin : p_state
      if (!ARESETn) begin
         r_rr_ptr    <= c_LAST_IDX;
         r_owner     <= '0;
         r_locked    <= 1'b0;
         r_hold_cnt  <= '0;
         r_rd_pend   <= '0;
         r_rvalid    <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_rvalid <= r_rd_pend;
         if (w_accept) begin
            r_rr_ptr    <= w_k;
            r_owner     <= w_k;
            r_locked    <= w_k_lock;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_k_we;
            r_mem_addr  <= w_k_addr;
            r_mem_wdata <= w_k_wdata;
            r_rd_pend   <= w_k_we ? '0 : w_gnt;
            if (w_k == r_owner) begin
               if (r_hold_cnt != c_HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
               r_hold_cnt <= HOLD_W'(1);
            end
         end else begin
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rd_pend <= '0;
            if (r_locked && !w_owner_req) begin
               r_locked   <= 1'b0;
               r_hold_cnt <= '0;
            end
         end
      end
   end

   assign bus.gnt       = ARESETn ? w_gnt : '0;
   assign bus.rvalid    = r_rvalid;
   assign bus.rdata     = bus.mem_rdata;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mem_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a behavioural arbiter/memory model.
// Revision : 1.0
// ============================================================================
module tb_axi4_mem_arbiter;
   localparam int N     = 2;
   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int MH    = 16;
   localparam int DEPTH = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   axi4_mem_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   axi4_mem_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)
   ) dut (
      .ACLK    (clk),
      .ARESETn (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Single-port memory with one-cycle read latency
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] mem_q;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            mem_q             <= mem[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = mem_q;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_rr, m_owner, m_hold;
   bit            m_locked;
   bit            e_en, e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;
   int            e_pend, e_rv;
   logic [DW-1:0] e_pend_d, e_rv_d;
   logic [DW-1:0] shadow [DEPTH];
   bit            undo_v;
   int            undo_a;
   logic [DW-1:0] undo_d;

   task automatic model_reset();
      m_rr = N - 1; m_owner = 0; m_hold = 0; m_locked = 0;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_pend = -1; e_rv = -1; e_pend_d = '0; e_rv_d = '0; undo_v = 0;
   endtask

   function automatic int exp_grant();
      bit others, forced;
      int start, idx;
      others = 0;
      for (int j = 0; j < N; j++) if (j != m_owner && bus.req[j]) others = 1;
      forced = m_locked && (m_hold == MH) && others;
      if (m_locked && bus.req[m_owner] && !forced) return m_owner;
      start = forced ? m_owner + 1 : m_rr + 1;
      for (int j = 0; j < N; j++) begin
         idx = (start + j) % N;
         if (!(forced && idx == m_owner) && bus.req[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_step(input int g);
      e_rv = e_pend; e_rv_d = e_pend_d; e_pend = -1; undo_v = 0;
      if (g >= 0) begin
         e_en    = 1;
         e_we    = bus.req_we[g];
         e_addr  = bus.req_addr[g*AW +: AW];
         e_wdata = bus.req_wdata[g*DW +: DW];
         if (e_we) begin
            undo_v = 1; undo_a = int'(e_addr); undo_d = shadow[e_addr];
            shadow[e_addr] = e_wdata;
         end else begin
            e_pend = g; e_pend_d = shadow[e_addr];
         end
         m_hold   = (g == m_owner) ? ((m_hold < MH) ? m_hold + 1 : MH) : 1;
         m_owner  = g;
         m_locked = bus.req_lock[g];
         m_rr     = g;
      end else begin
         e_en = 0; e_we = 0;
         if (m_locked && !bus.req[m_owner]) begin m_locked = 0; m_hold = 0; end
      end
   endtask

   always @(negedge clk) begin : p_cmp
      int         g;
      logic [N-1:0] g_oh, rv_oh;
      if (!rst_n) begin
         chk("rst_gnt",       bus.gnt,       0);
         chk("rst_mem_en",    bus.mem_en,    0);
         chk("rst_mem_we",    bus.mem_we,    0);
         chk("rst_mem_addr",  bus.mem_addr,  0);
         chk("rst_mem_wdata", bus.mem_wdata, 0);
         chk("rst_rvalid",    bus.rvalid,    0);
         // A write still sitting on the memory port never reaches memory
         if (e_en && e_we && undo_v) shadow[undo_a] = undo_d;
         model_reset();
      end else begin
         g = exp_grant();
         g_oh = '0;  if (g >= 0)    g_oh[g]     = 1'b1;
         rv_oh = '0; if (e_rv >= 0) rv_oh[e_rv] = 1'b1;
         chk("gnt",       bus.gnt,    g_oh);
         chk("mem_en",    bus.mem_en, e_en);
         chk("mem_we",    bus.mem_we, e_we);
         if (e_en) begin
            chk("mem_addr", bus.mem_addr, e_addr);
            if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
         end
         chk("rvalid", bus.rvalid, rv_oh);
         if (e_rv >= 0) chk("rdata", bus.rdata, e_rv_d);
         model_step(g);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input bit v, input bit we, input bit lk,
                        input int a, input logic [DW-1:0] d);
      bus.req[i]                 = v;
      bus.req_we[i]              = we;
      bus.req_lock[i]            = lk;
      bus.req_addr[i*AW +: AW]   = AW'(a);
      bus.req_wdata[i*DW +: DW]  = d;
   endtask

   logic [N-1:0]  fair_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [AW-1:0] fair_a [4] = '{10'h010, 10'h020, 10'h011, 10'h021};

   initial begin : p_stim
      logic [DW-1:0] v;
      logic [N-1:0]  gs, acc;
      int            a [N];
      bus.req = '0; bus.req_we = '0; bus.req_lock = '0;
      bus.req_addr = '0; bus.req_wdata = '0;
      mem_q = '0;
      model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         v = $urandom; mem[k] = v; shadow[k] = v;
      end
      mem[5] = 32'hDEADBEEF; shadow[5] = 32'hDEADBEEF;

      // Reset with both requesting
      drive(0, 1, 0, 0, 0, '0); drive(1, 1, 0, 0, 0, '0);
      repeat (3) tick();
      #1;
      chk("reset_gnt",    bus.gnt,    2'b00);
      chk("reset_mem_en", bus.mem_en, 1'b0);
      chk("reset_rvalid", bus.rvalid, 2'b00);
      rst_n = 1'b1;
      #1 chk("first_gnt", bus.gnt, 2'b01);
      tick();
      #1 chk("second_gnt", bus.gnt, 2'b10);
      tick();
      bus.req = '0;
      tick(); tick();

      // Fairness
      a[0] = 'h010; a[1] = 'h020;
      drive(0, 1, 0, 0, a[0], '0); drive(1, 1, 0, 0, a[1], '0);
      for (int c = 0; c < 4; c++) begin
         #1 chk("fair_gnt", bus.gnt, fair_g[c]);
         gs = bus.gnt;
         tick();
         for (int i = 0; i < N; i++) if (gs[i]) begin a[i]++; drive(i, 1, 0, 0, a[i], '0); end
         #1 chk("fair_addr", bus.mem_addr, fair_a[c]);
      end
      bus.req = '0;
      tick(); tick();

      // Read latency
      drive(1, 1, 0, 0, 5, '0);
      #1 chk("lat_gnt", bus.gnt, 2'b10);
      tick();
      bus.req = '0;
      #1;
      chk("lat_mem_en",   bus.mem_en,   1'b1);
      chk("lat_mem_we",   bus.mem_we,   1'b0);
      chk("lat_mem_addr", bus.mem_addr, 10'h005);
      chk("lat_rvalid0",  bus.rvalid,   2'b00);
      tick();
      #1;
      chk("lat_rvalid1", bus.rvalid, 2'b10);
      chk("lat_rdata",   bus.rdata,  32'hDEADBEEF);
      tick();
      #1 chk("lat_rvalid2", bus.rvalid, 2'b00);
      tick();

      // Locked burst
      drive(1, 1, 0, 0, 'h200, '0);
      for (int b = 0; b < 4; b++) begin
         drive(0, 1, 1, b < 3, 'h100 + b, 32'h1000 + b);
         #1 chk("burst_gnt", bus.gnt, 2'b01);
         tick();
      end
      bus.req[0] = 1'b0;
      #1 chk("burst_release", bus.gnt, 2'b10);
      tick();
      bus.req = '0;
      tick();

      // Hold limit
      drive(1, 1, 0, 0, 'h201, '0);
      for (int b = 0; b < MH; b++) begin
         drive(0, 1, 1, 1, 'h180 + b, $urandom);
         #1 chk("hold_gnt", bus.gnt, 2'b01);
         tick();
      end
      drive(0, 1, 1, 1, 'h190, $urandom);
      #1 chk("hold_force", bus.gnt, 2'b10);
      tick();
      #1 chk("hold_return", bus.gnt, 2'b01);
      tick();
      bus.req = '0;
      tick();

      // Write then read same address
      drive(0, 1, 1, 0, 'h3FF, 32'hA5A5A5A5);
      #1 chk("raw_wr_gnt", bus.gnt, 2'b01);
      tick();
      bus.req[0] = 1'b0;
      drive(1, 1, 0, 0, 'h3FF, '0);
      #1 chk("raw_rd_gnt", bus.gnt, 2'b10);
      tick();
      bus.req = '0;
      tick();
      #1;
      chk("raw_rvalid", bus.rvalid, 2'b10);
      chk("raw_rdata",  bus.rdata,  32'hA5A5A5A5);
      tick();

      // Same, aborted by reset right after the read is accepted
      drive(0, 1, 1, 0, 'h3FF, 32'h5A5A5A5A);
      tick();
      bus.req[0] = 1'b0;
      drive(1, 1, 0, 0, 'h3FF, '0);
      tick();
      bus.req = '0;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_en",    bus.mem_en,    1'b0);
      chk("abort_mem_we",    bus.mem_we,    1'b0);
      chk("abort_mem_addr",  bus.mem_addr,  10'h000);
      chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
      chk("abort_gnt",       bus.gnt,       2'b00);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1 chk("abort_rvalid", bus.rvalid, 2'b00);
         tick();
      end

      // Randomized traffic: light locking, then heavy locking with persistent requests
      for (int ph = 0; ph < 2; ph++) begin
         for (int cyc = 0; cyc < 1500; cyc++) begin
            #2 acc = bus.req & bus.gnt;
            tick();
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) begin
               if (acc[i] || !bus.req[i]) begin
                  drive(i,
                        $urandom_range(0, 99) < ((ph == 0) ? 70 : 97),
                        $urandom_range(0, 1) == 1,
                        $urandom_range(0, 99) < ((ph == 0) ? 25 : 90),
                        ($urandom_range(0, 3) == 0) ? 'h3FF : int'($urandom_range(0, 15)),
                        $urandom);
               end
            end
         end
      end
      rst_n = 1'b1;
      bus.req = '0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/axi4_mem_arbiter.md
# axi4_mem_arbiter

Round-robin arbiter that shares the single-port `axi4_memory` instance between NUM_REQ requesters, e.g. the AXI4 slave datapath, an init/scrub engine and a debug port. Each requester issues single-word accesses. A requester can lock the grant across a burst, and a hold limit prevents starvation. Accesses are registered onto the memory port. Read data is routed back with a per-requester valid strobe.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (≥2)
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 10, word address width ($clog2 of memory depth)
- MAX_HOLD, 16, max consecutive accepted accesses by one owner while another requester waits

Ports (vector slice i belongs to requester i; wide buses are sliced `[i*W +: W]`):
- Clock and reset: one clock, ACLK; reset ARESETn is asynchronous and active-low.
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req  in  NUM_REQ  requester i presents an access this cycle
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  keep grant after this access (more beats follow)
- req_addr  in  NUM_REQ*ADDR_WIDTH  word address
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data
- gnt  out  NUM_REQ  one-hot grant, combinational; access accepted on an edge where req[i]&gnt[i]
- rvalid  out  NUM_REQ  read data for requester i valid this cycle
- rdata  out  DATA_WIDTH  read data, equals mem_rdata; qualify with rvalid
- mem_en  out  1  memory enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_WIDTH  memory word address (registered)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read mem_en cycle

## Operation
- State:
  - rr_ptr: last granted index
  - owner, locked: lock state
  - hold_cnt: width $clog2(MAX_HOLD+1)
  - rd_pend[NUM_REQ]: read-return pipeline
- gnt computation, in priority order:
  1. If locked and req[owner] is high and not forced out, grant owner.
  2. Otherwise grant the first requesting i, searching cyclically from rr_ptr+1.
  3. If no req, gnt=0.
- Forced out: locked, hold_cnt==MAX_HOLD, and any other req is high. The owner is skipped this cycle; the round-robin search starts at owner+1 and excludes the owner.
- On acceptance by requester k:
  - rr_ptr←k.
  - mem_en←1, mem_we←req_we[k], mem_addr and mem_wdata ← slice k.
  - locked←req_lock[k], owner←k.
  - hold_cnt: increments (saturating at MAX_HOLD) if k==owner; otherwise set to 1.
- No acceptance in a cycle:
  - mem_en←0, mem_we←0; mem_addr and mem_wdata hold.
  - If the owner drops req while locked, locked←0 and hold_cnt←0.
- Read return: rd_pend←one-hot(k) when a read is accepted, else 0. rvalid is the rd_pend value one cycle later, aligned with mem_rdata.
- Writes produce no response. The write is complete when it is accepted.
- Ordering: accesses reach memory in acceptance order. A read accepted after a write to the same address returns the new data.

## Timing
- Reset (asynchronous, immediate):
  - gnt=0 (forced while ARESETn low), mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rvalid=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - locked=0, hold_cnt=0, rd_pend=0.
- Accept at edge T:
  - mem_en/mem_we/mem_addr/mem_wdata are valid during cycle T→T+1.
  - For a read, rvalid[k]=1 and rdata is valid during cycle T+1→T+2 (latency 2 from acceptance).
- Throughput: one access per cycle, back to back, across any requesters; no bubble on grant switch.
- gnt depends only on current req/req_lock and registered state. The requester holds its request fields stable while req is high and not accepted.
- Reset mid-operation: an in-flight read's rvalid is never asserted; mem_en drops the instant ARESETn falls.

## Test plan
- Reset: hold ARESETn=0 with req=2'b11 → gnt=0, mem_en=0, rvalid=0. Release → first gnt=2'b01, then 2'b10 on the next edge.
- Fairness: both requesters continuously issue unlocked reads, req0 at 0x010.., req1 at 0x020.. → gnt alternates 01,10,01,10. mem_addr sequence is 0x010, 0x020, 0x011, 0x021.
- Read latency: word 0x005 preloaded with 0xDEADBEEF; req1 reads 0x005, accepted at edge T → mem_en=1, mem_we=0, mem_addr=0x005 in cycle T+1; rvalid=2'b10 and rdata=0xDEADBEEF in cycle T+2; rvalid is 0 in every other cycle.
- Locked burst: req0 issues 4 writes with lock=1,1,1,0 to 0x100..0x103 while req1 is waiting → gnt=01 for 4 consecutive accepted beats, then gnt=10 on the next cycle.
- Hold limit (MAX_HOLD=16): req0 issues continuous locked writes while req1 waits → req0 gets 16 accepted beats, req1 is granted on beat 17, and the next grant returns to req0 (locked=0 at that point).
- Write/read ordering and reset abort: req0 writes 0xA5A5A5A5 to 0x3FF, then req1 reads 0x3FF next cycle → rdata=0xA5A5A5A5. Repeat with ARESETn pulsed low one cycle after the read is accepted → no rvalid, and all memory outputs are 0.
